// File: rtl/pos_mask_builder.sv
// Rebuilds a multi-hot bit vector from a framed stream of bit positions and
// emits mask, distinct-bit count and duplicate flag through a registered slot.
module pos_mask_builder #(
  parameter int POS_W = 3,
  localparam int N = 2 ** POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_mask,
  output logic [POS_W:0]   out_count,
  output logic             out_dup
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       acc_mask_q, acc_mask_d;
  logic               acc_dup_q, acc_dup_d;
  logic               out_valid_q, out_valid_d;
  logic [N-1:0]       out_mask_q, out_mask_d;
  logic [POS_W:0]     out_count_q, out_count_d;
  logic               out_dup_q, out_dup_d;
  logic               accept_s;
  logic [N-1:0]       pos_bit_s;
  logic [N-1:0]       final_mask_s;

  function automatic logic [POS_W:0] popcount(input logic [N-1:0] vec);
    logic [POS_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{POS_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Any held output stalls every input beat, last or not.
  assign in_ready     = !out_valid_q || out_ready;
  assign accept_s     = in_valid && in_ready;
  assign pos_bit_s    = {{(N-1){1'b0}}, 1'b1} << in_pos;
  assign final_mask_s = acc_mask_q | pos_bit_s;

  // Next-state: accumulator, frame state and output slot.
  always_comb begin
    state_d     = state_q;
    acc_mask_d  = acc_mask_q;
    acc_dup_d   = acc_dup_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    out_dup_d   = out_dup_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (accept_s) begin
      if (in_last) begin
        // Load the slot and clear the accumulator on the same edge.
        out_mask_d  = final_mask_s;
        out_count_d = popcount(final_mask_s);
        out_dup_d   = acc_dup_q | acc_mask_q[in_pos];
        out_valid_d = 1'b1;
        acc_mask_d  = '0;
        acc_dup_d   = 1'b0;
        state_d     = IDLE;
      end else begin
        acc_mask_d = final_mask_s;
        acc_dup_d  = acc_dup_q | acc_mask_q[in_pos];
        case (state_q)
          IDLE:    state_d = ACCUM;
          ACCUM:   state_d = ACCUM;
          default: state_d = ACCUM;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_mask_q  <= '0;
      acc_dup_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_dup_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_mask_q  <= acc_mask_d;
      acc_dup_q   <= acc_dup_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      out_dup_q   <= out_dup_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;
  assign out_dup   = out_dup_q;

endmodule

// File: tb/tb_pos_mask_builder.sv
// Directed bench for pos_mask_builder with hand-computed expected frame results.
module tb_pos_mask_builder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_pos;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       out_dup;

  int checks_q;
  int errors_q;

  pos_mask_builder #(.POS_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_dup   (out_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_q++;
    if (obs !== exp) begin
      errors_q++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, waits (bounded) for acceptance, then drops valid.
  task automatic send_beat(input logic [2:0] pos, input logic last);
    int n;
    in_valid = 1'b1;
    in_pos   = pos;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] m,
                         input logic [3:0] c, input logic d);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_mask"},  {24'd0, out_mask},  {24'd0, m});
    chk({tag, "_count"}, {28'd0, out_count}, {28'd0, c});
    chk({tag, "_dup"},   {31'd0, out_dup},   {31'd0, d});
  endtask

  initial begin
    checks_q  = 0;
    errors_q  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pos    = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_out("reset", 1'b0, 8'h00, 4'd0, 1'b0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Frame 0,3,7
    send_beat(3'd0, 1'b0);
    chk("no_out_midframe", {31'd0, out_valid}, 32'd0);
    send_beat(3'd3, 1'b0);
    send_beat(3'd7, 1'b1);
    chk_out("f037", 1'b1, 8'b1000_1001, 4'd3, 1'b0);
    tick();
    chk("f037_consumed", {31'd0, out_valid}, 32'd0);

    // Duplicate frame, then accumulator-cleared check
    send_beat(3'd2, 1'b0);
    send_beat(3'd2, 1'b1);
    chk_out("dup22", 1'b1, 8'b0000_0100, 4'd1, 1'b1);
    send_beat(3'd4, 1'b1);
    chk_out("after_dup", 1'b1, 8'b0001_0000, 4'd1, 1'b0);
    tick();

    // Full mask
    for (int i = 0; i < 8; i++) begin
      send_beat(i[2:0], (i == 7));
    end
    chk_out("all8", 1'b1, 8'hFF, 4'd8, 1'b0);
    tick();

    // Back-pressure stall
    out_ready = 1'b0;
    send_beat(3'd5, 1'b1);
    chk_out("stall_load", 1'b1, 8'b0010_0000, 4'd1, 1'b0);
    in_valid = 1'b1;
    in_pos   = 3'd6;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk_out("stall_hold", 1'b1, 8'b0010_0000, 4'd1, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("release_frame", 1'b1, 8'b0100_0000, 4'd1, 1'b0);
    tick();
    chk("release_drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back single-beat frames, no bubble
    in_valid = 1'b1;
    in_pos   = 3'd1;
    in_last  = 1'b1;
    tick();
    chk_out("b2b_first", 1'b1, 8'h02, 4'd1, 1'b0);
    in_pos = 3'd6;
    tick();
    in_valid = 1'b0;
    chk_out("b2b_second", 1'b1, 8'h40, 4'd1, 1'b0);
    tick();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-frame discards the partial accumulator
    send_beat(3'd3, 1'b0);
    send_beat(3'd4, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("midreset", 1'b0, 8'h00, 4'd0, 1'b0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    send_beat(3'd0, 1'b1);
    chk_out("post_reset", 1'b1, 8'h01, 4'd1, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
